// File: rtl/prbs4_checker_if.sv
// Stream interface between a PRBS4 source and the checker.
// The source drives words in; the checker drives lock and error status back.
interface prbs4_checker_if #(
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [3:0]       in_data;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, in_data, clr_err,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_data, clr_err,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/prbs4_checker.sv
// Self-synchronising checker for the x^4+x^3+1 LFSR stream.
// Optional macro PRBS4_CHK_ZERO_DET_EN treats an all-zero word as never valid.
module prbs4_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  prbs4_checker_if.slave bus
);

`ifdef PRBS4_CHK_ZERO_DET_EN
  localparam bit ZeroDetEn = 1'b1;
`else
  localparam bit ZeroDetEn = 1'b0;
`endif

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       exp_q, exp_d;
  logic             haveSeed_q, haveSeed_d;
  logic [3:0]       run_q, run_d;
  logic             errPulse_q, errPulse_d;
  logic [ERR_W-1:0] errCount_q, errCount_d;
  logic [4:0]       runInc;
  logic             isZero;

  function automatic logic [3:0] nextWord(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  assign runInc = {1'b0, run_q} + 5'd1;
  assign isZero = ZeroDetEn && (bus.in_data == 4'd0);

  // Once locked the prediction free-runs from exp_q, so a single corrupt word costs exactly one error.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    haveSeed_d = haveSeed_q;
    run_d      = run_q;
    errPulse_d = 1'b0;
    errCount_d = errCount_q;

    if (bus.in_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (isZero) begin
            haveSeed_d = 1'b0;
            run_d      = 4'd0;
          end else if (!haveSeed_q) begin
            exp_d      = nextWord(bus.in_data);
            haveSeed_d = 1'b1;
            run_d      = 4'd0;
          end else if (bus.in_data == exp_q) begin
            exp_d = nextWord(bus.in_data);
            if (runInc == 5'(LOCK_CNT)) begin
              state_d = LOCKED;
              run_d   = 4'd0;
            end else begin
              run_d = runInc[3:0];
            end
          end else begin
            run_d = 4'd0;
            exp_d = nextWord(bus.in_data);
          end
        end
        LOCKED: begin
          exp_d = nextWord(exp_q);
          if (bus.in_data == exp_q && !isZero) begin
            run_d = 4'd0;
          end else begin
            errPulse_d = 1'b1;
            if (errCount_q != '1) errCount_d = errCount_q + ERR_W'(1);
            if (runInc == 5'(UNLOCK_CNT)) begin
              state_d    = SEARCH;
              run_d      = 4'd0;
              exp_d      = nextWord(bus.in_data);
              haveSeed_d = 1'b1;
            end else begin
              run_d = runInc[3:0];
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (bus.clr_err) errCount_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEARCH;
      exp_q      <= 4'd0;
      haveSeed_q <= 1'b0;
      run_q      <= 4'd0;
      errPulse_q <= 1'b0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      haveSeed_q <= haveSeed_d;
      run_q      <= run_d;
      errPulse_q <= errPulse_d;
      errCount_q <= errCount_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = errPulse_q;
  assign bus.err_count = errCount_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: hand-computed vector table plus a reference model feeding a scoreboard.
module tb_prbs4_checker;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int ERR_W      = 8;
  localparam int CNT_MAX    = (1 << ERR_W) - 1;
`ifdef PRBS4_CHK_ZERO_DET_EN
  localparam bit ZERO_DET = 1'b1;
`else
  localparam bit ZERO_DET = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  prbs4_checker_if #(.ERR_W(ERR_W)) bus();

  prbs4_checker #(
    .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             locked;
    logic             pulse;
    logic [ERR_W-1:0] count;
  } obs_t;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       c;
    obs_t       exp;
  } vec_t;

  obs_t sb[$];
  int total = 0;
  int bad = 0;

  logic [3:0] mExp;
  bit mSeed, mLocked, mPulse;
  int mRun, mCount;
  logic [3:0] gWord;

  function automatic logic [3:0] nxt(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  function automatic vec_t mkVec(input logic v, input logic [3:0] d, input logic c,
                                 input logic l, input logic p, input int cnt);
    vec_t r;
    r.v = v; r.d = d; r.c = c;
    r.exp.locked = l; r.exp.pulse = p; r.exp.count = ERR_W'(cnt);
    return r;
  endfunction

  task automatic modelReset();
    mExp = 4'd0; mSeed = 0; mLocked = 0; mPulse = 0; mRun = 0; mCount = 0;
  endtask

  // Behavioural reference of the checker's per-word rules.
  task automatic modelStep(input logic v, input logic [3:0] d, input logic c);
    bit zero;
    logic [3:0] predicted;
    zero = ZERO_DET && (d == 4'd0);
    mPulse = 0;
    if (v) begin
      if (!mLocked) begin
        if (zero) begin
          mSeed = 0; mRun = 0;
        end else if (!mSeed) begin
          mExp = nxt(d); mSeed = 1; mRun = 0;
        end else if (d == mExp) begin
          mRun++; mExp = nxt(d);
          if (mRun == LOCK_CNT) begin mLocked = 1; mRun = 0; end
        end else begin
          mRun = 0; mExp = nxt(d);
        end
      end else begin
        predicted = nxt(mExp);
        if (d == mExp && !zero) begin
          mRun = 0; mExp = predicted;
        end else begin
          mPulse = 1;
          if (mCount < CNT_MAX) mCount++;
          mRun++; mExp = predicted;
          if (mRun == UNLOCK_CNT) begin
            mLocked = 0; mRun = 0; mExp = nxt(d); mSeed = 1;
          end
        end
      end
    end
    if (c) mCount = 0;
  endtask

  function automatic obs_t modelObs();
    obs_t o;
    o.locked = mLocked; o.pulse = mPulse; o.count = ERR_W'(mCount);
    return o;
  endfunction

  task automatic checkOutput(input string name);
    obs_t e, a;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: scoreboard empty, nothing to compare", name);
      return;
    end
    e = sb.pop_front();
    a.locked = bus.locked; a.pulse = bus.err_pulse; a.count = bus.err_count;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL %s: got locked=%0b pulse=%0b count=%0d, want locked=%0b pulse=%0b count=%0d",
               name, a.locked, a.pulse, a.count, e.locked, e.pulse, e.count);
    end
  endtask

  task automatic checkNow(input string name, input int actual, input int want);
    total++;
    if (actual != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, want);
    end
  endtask

  task automatic driveOne(input logic v, input logic [3:0] d, input logic c,
                          input obs_t e, input string name);
    bus.in_valid = v; bus.in_data = d; bus.clr_err = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(name);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic c, input string name);
    modelStep(v, d, c);
    driveOne(v, d, c, modelObs(), name);
  endtask

  task automatic sendClean(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, gWord, 1'b0, name);
      gWord = nxt(gWord);
    end
  endtask

  task automatic sendBad(input logic c, input string name);
    applyStimulus(1'b1, gWord ^ 4'b0001, c, name);
    gWord = nxt(gWord);
  endtask

  task automatic doReset(input string name);
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 4'd0; bus.clr_err = 1'b0;
    #1;
    checkNow({name, "_locked"}, int'(bus.locked), 0);
    checkNow({name, "_pulse"}, int'(bus.err_pulse), 0);
    checkNow({name, "_count"}, int'(bus.err_count), 0);
    modelReset();
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mkVec(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 0);
    tbl[1]  = mkVec(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 0);
    tbl[2]  = mkVec(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 0);
    tbl[3]  = mkVec(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 0);
    tbl[4]  = mkVec(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 0);
    tbl[5]  = mkVec(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 0);
    tbl[6]  = mkVec(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 0);
    tbl[7]  = mkVec(1'b1, 4'b1100, 1'b0, 1'b1, 1'b1, 1);
    tbl[8]  = mkVec(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1);
    tbl[9]  = mkVec(1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 0);
    tbl[10] = mkVec(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 0);

    bus.in_valid = 1'b0; bus.in_data = 4'd0; bus.clr_err = 1'b0;
    #2;
    doReset("reset");

    for (int i = 0; i < 11; i++) begin
      modelStep(tbl[i].v, tbl[i].d, tbl[i].c);
      driveOne(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].exp, $sformatf("table%0d", i));
    end
    gWord = nxt(4'b0101);

    sendClean(30, "clean30");

    for (int i = 0; i < UNLOCK_CNT; i++) sendBad(1'b0, "unlockBurst");
    checkNow("unlocked", int'(bus.locked), 0);
    sendClean(8, "relock");
    checkNow("relocked", int'(bus.locked), 1);

    for (int i = 0; i < 300; i++) begin
      sendBad(1'b0, "satBad");
      sendClean(1, "satClean");
    end
    checkNow("saturated", int'(bus.err_count), CNT_MAX);
    sendBad(1'b1, "clrWithErr");

    #2;
    doReset("midLockReset");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, gWord, 1'b0, "gapValid");
      gWord = nxt(gWord);
      applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1'b0, "gapIdle");
    end
    checkNow("gapLocked", int'(bus.locked), 1);

    doReset("zeroReset");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'd0, 1'b0, "constZero");
    checkNow("zeroLock", int'(bus.locked), ZERO_DET ? 0 : 1);

    doReset("zeroLockedReset");
    gWord = 4'b1000;
    sendClean(6, "preZero");
    applyStimulus(1'b1, 4'd0, 1'b0, "zeroWhileLocked");
    gWord = nxt(gWord);
    sendClean(3, "postZero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
